// File: rtl/vx_commit_pkg.sv
// Shared types and width helpers for the vx_commit_arb commit stage.
package vx_commit_pkg;

  localparam int unsigned CFG_NUM_CH      = 7;
  localparam int unsigned CFG_NUM_THREADS = 4;
  localparam int unsigned CFG_NUM_WARPS   = 4;
  localparam int unsigned CFG_XLEN        = 32;
  localparam int unsigned CFG_NR_BITS     = 5;
  localparam int unsigned CFG_CNT_W       = 64;

  function automatic int unsigned calc_wid_w(input int unsigned num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  function automatic int unsigned calc_size_w(input int unsigned num_ch,
                                              input int unsigned num_threads);
    return $clog2(num_ch * num_threads + 1);
  endfunction

  localparam int unsigned CFG_WID_W = calc_wid_w(CFG_NUM_WARPS);

  // One writeback payload, sized by the core configuration above.
  typedef struct packed {
    logic [CFG_WID_W-1:0]                wid;
    logic [CFG_NUM_THREADS-1:0]          tmask;
    logic [CFG_NR_BITS-1:0]              rd;
    logic [CFG_NUM_THREADS*CFG_XLEN-1:0] data;
  } commit_req_t;

endpackage

// File: rtl/vx_commit_arb_if.sv
// Commit channel, writeback and commit-report signals of vx_commit_arb.
interface vx_commit_arb_if #(
  parameter int unsigned NUM_CH      = vx_commit_pkg::CFG_NUM_CH,
  parameter int unsigned NUM_THREADS = vx_commit_pkg::CFG_NUM_THREADS,
  parameter int unsigned NUM_WARPS   = vx_commit_pkg::CFG_NUM_WARPS,
  parameter int unsigned XLEN        = vx_commit_pkg::CFG_XLEN,
  parameter int unsigned NR_BITS     = vx_commit_pkg::CFG_NR_BITS,
  parameter int unsigned CNT_W       = vx_commit_pkg::CFG_CNT_W
);
  localparam int unsigned WID_W  = vx_commit_pkg::calc_wid_w(NUM_WARPS);
  localparam int unsigned SIZE_W = vx_commit_pkg::calc_size_w(NUM_CH, NUM_THREADS);

  logic [NUM_CH-1:0]                  ch_valid;
  logic [NUM_CH-1:0]                  ch_ready;
  logic [NUM_CH-1:0]                  ch_wb;
  logic [NUM_CH*WID_W-1:0]            ch_wid;
  logic [NUM_CH*NUM_THREADS-1:0]      ch_tmask;
  logic [NUM_CH*NR_BITS-1:0]          ch_rd;
  logic [NUM_CH*NUM_THREADS*XLEN-1:0] ch_data;

  logic                        wb_valid;
  logic                        wb_ready;
  logic [WID_W-1:0]            wb_wid;
  logic [NUM_THREADS-1:0]      wb_tmask;
  logic [NR_BITS-1:0]          wb_rd;
  logic [NUM_THREADS*XLEN-1:0] wb_data;

  logic              cmt_valid;
  logic [SIZE_W-1:0] cmt_size;
  logic [CNT_W-1:0]  perf_instrs;
  logic [CNT_W-1:0]  perf_threads;

  modport master (
    output ch_valid, ch_wb, ch_wid, ch_tmask, ch_rd, ch_data, wb_ready,
    input  ch_ready, wb_valid, wb_wid, wb_tmask, wb_rd, wb_data,
    input  cmt_valid, cmt_size, perf_instrs, perf_threads
  );

  modport slave (
    input  ch_valid, ch_wb, ch_wid, ch_tmask, ch_rd, ch_data, wb_ready,
    output ch_ready, wb_valid, wb_wid, wb_tmask, wb_rd, wb_data,
    output cmt_valid, cmt_size, perf_instrs, perf_threads
  );

endinterface

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or above the pointer wins.
module vx_rr_arbiter #(
  parameter int unsigned N    = 7,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic            advance_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned j;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IdxW'(j);
      end
    end
  end

  // advance_i is only raised with a live grant, so idx_o is meaningful here.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (32'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vx_commit_arb.sv
// Commit stage: round-robin writeback arbitration plus committed-thread reporting.
// Optional counters under VX_COMMIT_PERF_EN; otherwise perf ports are tied to 0.
module vx_commit_arb
  import vx_commit_pkg::*;
#(
  parameter int unsigned NUM_CH      = CFG_NUM_CH,
  parameter int unsigned NUM_THREADS = CFG_NUM_THREADS,
  parameter int unsigned NUM_WARPS   = CFG_NUM_WARPS,
  parameter int unsigned XLEN        = CFG_XLEN,
  parameter int unsigned NR_BITS     = CFG_NR_BITS,
  parameter int unsigned CNT_W       = CFG_CNT_W
) (
  input logic            clk,
  input logic            reset,
  vx_commit_arb_if.slave bus
);

  localparam int unsigned WID_W  = calc_wid_w(NUM_WARPS);
  localparam int unsigned SIZE_W = calc_size_w(NUM_CH, NUM_THREADS);
  localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DW     = NUM_THREADS * XLEN;

  logic [NUM_CH-1:0] wr_req, grant, ch_ready, fire;
  logic [IDX_W-1:0]  grant_idx;
  logic              out_free, load;

  commit_req_t       sel_req, wb_q, wb_d;
  logic              wb_valid_q, wb_valid_d;
  logic              cmt_valid_q, cmt_valid_d;
  logic [SIZE_W-1:0] cmt_size_q, cmt_size_d;

  assign wr_req   = bus.ch_valid & bus.ch_wb;
  assign out_free = ~wb_valid_q | bus.wb_ready;
  assign load     = (|grant) & out_free;

  vx_rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .clk_i     (clk),
    .rst_ni    (reset),
    .req_i     (wr_req),
    .advance_i (load),
    .grant_o   (grant),
    .idx_o     (grant_idx)
  );

  // Non-writing channels never contend; writers need the grant and a free slot.
  always_comb begin
    ch_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_ready[i] = bus.ch_wb[i] ? (grant[i] & out_free) : 1'b1;
    end
  end

  assign bus.ch_ready = ch_ready;
  assign fire         = bus.ch_valid & ch_ready;

  always_comb begin
    sel_req       = '0;
    sel_req.wid   = bus.ch_wid[32'(grant_idx) * WID_W +: WID_W];
    sel_req.tmask = bus.ch_tmask[32'(grant_idx) * NUM_THREADS +: NUM_THREADS];
    sel_req.rd    = bus.ch_rd[32'(grant_idx) * NR_BITS +: NR_BITS];
    sel_req.data  = bus.ch_data[32'(grant_idx) * DW +: DW];
  end

  always_comb begin
    cmt_size_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (fire[i]) begin
        cmt_size_d = cmt_size_d
                   + SIZE_W'($countones(bus.ch_tmask[i*NUM_THREADS +: NUM_THREADS]));
      end
    end
    cmt_valid_d = |fire;
  end

  // A new load wins over a drain, so back-to-back writebacks stream at full rate.
  always_comb begin
    wb_valid_d = load | (wb_valid_q & ~bus.wb_ready);
    wb_d       = load ? sel_req : wb_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q  <= 1'b0;
      wb_q        <= '0;
      cmt_valid_q <= 1'b0;
      cmt_size_q  <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_q        <= wb_d;
      cmt_valid_q <= cmt_valid_d;
      cmt_size_q  <= cmt_size_d;
    end
  end

  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_wid    = wb_q.wid;
  assign bus.wb_tmask  = wb_q.tmask;
  assign bus.wb_rd     = wb_q.rd;
  assign bus.wb_data   = wb_q.data;
  assign bus.cmt_valid = cmt_valid_q;
  assign bus.cmt_size  = cmt_size_q;

`ifdef VX_COMMIT_PERF_EN
  logic [CNT_W-1:0] perf_instrs_q, perf_instrs_d;
  logic [CNT_W-1:0] perf_threads_q, perf_threads_d;

  always_comb begin
    perf_instrs_d  = perf_instrs_q + CNT_W'($countones(fire));
    perf_threads_d = perf_threads_q + CNT_W'(cmt_size_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_instrs_q  <= '0;
      perf_threads_q <= '0;
    end else begin
      perf_instrs_q  <= perf_instrs_d;
      perf_threads_q <= perf_threads_d;
    end
  end

  assign bus.perf_instrs  = perf_instrs_q;
  assign bus.perf_threads = perf_threads_q;
`else
  assign bus.perf_instrs  = {CNT_W{1'b0}};
  assign bus.perf_threads = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed self-checking bench for vx_commit_arb with hand-computed expectations.
module tb_vx_commit_arb;

  localparam int unsigned NUM_CH      = 7;
  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned NUM_WARPS   = 4;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned NR_BITS     = 5;
  localparam int unsigned CNT_W       = 64;
  localparam int unsigned WID_W       = 2;
  localparam int unsigned DW          = NUM_THREADS * XLEN;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vx_commit_arb_if #(
    .NUM_CH      (NUM_CH),
    .NUM_THREADS (NUM_THREADS),
    .NUM_WARPS   (NUM_WARPS),
    .XLEN        (XLEN),
    .NR_BITS     (NR_BITS),
    .CNT_W       (CNT_W)
  ) bus ();

  vx_commit_arb #(
    .NUM_CH      (NUM_CH),
    .NUM_THREADS (NUM_THREADS),
    .NUM_WARPS   (NUM_WARPS),
    .XLEN        (XLEN),
    .NR_BITS     (NR_BITS),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int unsigned ch, input int unsigned tag);
    logic [DW-1:0] d;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      d[t*XLEN +: XLEN] = XLEN'(32'hC0DE_0000 + tag * 4096 + ch * 16 + t);
    end
    return d;
  endfunction

  task automatic idle();
    bus.ch_valid = '0;
    bus.ch_wb    = '0;
    bus.ch_wid   = '0;
    bus.ch_tmask = '0;
    bus.ch_rd    = '0;
    bus.ch_data  = '0;
  endtask

  task automatic drive(input int unsigned ch, input logic wb, input logic [3:0] tm,
                       input int unsigned tag);
    bus.ch_valid[ch]                      = 1'b1;
    bus.ch_wb[ch]                         = wb;
    bus.ch_wid[ch*WID_W +: WID_W]         = WID_W'(ch);
    bus.ch_tmask[ch*NUM_THREADS +: NUM_THREADS] = tm;
    bus.ch_rd[ch*NR_BITS +: NR_BITS]      = NR_BITS'(ch + 10);
    bus.ch_data[ch*DW +: DW]              = pat(ch, tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned   rr_exp [4] = '{0, 2, 5, 0};
  logic [6:0]    rdy_exp;
  logic [CNT_W-1:0] exp_instrs, exp_threads;

  initial begin
    reset = 1'b0;
    idle();
    bus.wb_ready = 1'b1;
    step();
    step();
    check_eq("rst_wb_valid", bus.wb_valid, 0);
    check_eq("rst_cmt_valid", bus.cmt_valid, 0);
    check_eq("rst_cmt_size", bus.cmt_size, 0);
    check_eq("rst_wb_rd", bus.wb_rd, 0);
    check_eq("rst_perf_instrs", bus.perf_instrs, 0);
    check_eq("rst_perf_threads", bus.perf_threads, 0);
    reset = 1'b1;
    step();

    // Single write on ch0
    drive(0, 1'b1, 4'b1011, 1);
    #1;
    check_eq("single_ready", bus.ch_ready[0], 1);
    step();
    idle();
    check_eq("single_wb_valid", bus.wb_valid, 1);
    check_eq("single_wb_rd", bus.wb_rd, 10);
    check_eq("single_wb_tmask", bus.wb_tmask, 4'b1011);
    check_eq("single_wb_wid", bus.wb_wid, 0);
    check_eq("single_wb_data", bus.wb_data, pat(0, 1));
    check_eq("single_cmt_valid", bus.cmt_valid, 1);
    check_eq("single_cmt_size", bus.cmt_size, 3);
    step();
    check_eq("single_drain_valid", bus.wb_valid, 0);
    check_eq("single_drain_cmt", bus.cmt_valid, 0);

    // Round-robin over ch0/2/5 from a fresh pointer
    reset = 1'b0;
    #1;
    reset = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      idle();
      drive(0, 1'b1, 4'hF, k);
      drive(2, 1'b1, 4'hF, k);
      drive(5, 1'b1, 4'hF, k);
      #1;
      rdy_exp = 7'b1011010 | (7'b1 << rr_exp[k]);
      check_eq($sformatf("rr%0d_ready", k), bus.ch_ready, rdy_exp);
      step();
      check_eq($sformatf("rr%0d_wb_valid", k), bus.wb_valid, 1);
      check_eq($sformatf("rr%0d_wb_rd", k), bus.wb_rd, rr_exp[k] + 10);
      check_eq($sformatf("rr%0d_wb_data", k), bus.wb_data, pat(rr_exp[k], k));
      check_eq($sformatf("rr%0d_cmt_size", k), bus.cmt_size, 4);
    end
    idle();
    step();
    check_eq("rr_drain", bus.wb_valid, 0);

    // Backpressure on ch1
    bus.wb_ready = 1'b0;
    drive(1, 1'b1, 4'h7, 7);
    #1;
    check_eq("bp_ready_empty", bus.ch_ready[1], 1);
    step();
    check_eq("bp_load_valid", bus.wb_valid, 1);
    check_eq("bp_load_rd", bus.wb_rd, 11);
    drive(1, 1'b1, 4'h7, 8);
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq($sformatf("bp%0d_ready", k), bus.ch_ready[1], 0);
      step();
      check_eq($sformatf("bp%0d_valid", k), bus.wb_valid, 1);
      check_eq($sformatf("bp%0d_data", k), bus.wb_data, pat(1, 7));
    end
    bus.wb_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", bus.ch_ready[1], 1);
    step();
    check_eq("bp_reload_valid", bus.wb_valid, 1);
    check_eq("bp_reload_data", bus.wb_data, pat(1, 8));
    idle();
    step();
    check_eq("bp_drain", bus.wb_valid, 0);

    // Store and write in one cycle
    drive(3, 1'b0, 4'hF, 0);
    drive(0, 1'b1, 4'h3, 9);
    #1;
    check_eq("mix_ready", bus.ch_ready, 7'h7F);
    step();
    check_eq("mix_cmt_size", bus.cmt_size, 6);
    check_eq("mix_cmt_valid", bus.cmt_valid, 1);
    check_eq("mix_wb_valid", bus.wb_valid, 1);
    check_eq("mix_wb_rd", bus.wb_rd, 10);
    check_eq("mix_wb_tmask", bus.wb_tmask, 4'h3);

    // Maximum commit: one writer plus six stores (pointer now 1)
    idle();
    for (int unsigned c = 0; c < NUM_CH; c++) drive(c, c == 0, 4'hF, 2);
    #1;
    check_eq("max_ready", bus.ch_ready, 7'h7F);
    step();
    check_eq("max_cmt_size", bus.cmt_size, 28);

    // Two writers: only the grantee (ch1) commits alongside five stores
    idle();
    for (int unsigned c = 0; c < NUM_CH; c++) drive(c, c < 2, 4'hF, 3);
    #1;
    check_eq("two_wr_ready", bus.ch_ready, 7'b1111110);
    step();
    check_eq("two_wr_cmt_size", bus.cmt_size, 24);
    check_eq("two_wr_wb_rd", bus.wb_rd, 11);

    // Empty tmask still fires
    idle();
    drive(4, 1'b0, 4'h0, 0);
    step();
    check_eq("zero_tm_cmt_valid", bus.cmt_valid, 1);
    check_eq("zero_tm_cmt_size", bus.cmt_size, 0);
    check_eq("zero_tm_wb_valid", bus.wb_valid, 0);

    // Reset with a writeback in flight (ch3 grant moves pointer to 4)
    idle();
    drive(3, 1'b1, 4'hF, 4);
    step();
    idle();
    bus.wb_ready = 1'b0;
    #1;
    check_eq("mid_pre_valid", bus.wb_valid, 1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_valid", bus.wb_valid, 0);
    check_eq("mid_rst_rd", bus.wb_rd, 0);
    check_eq("mid_rst_data", bus.wb_data, 0);
    check_eq("mid_rst_cmt_valid", bus.cmt_valid, 0);
    check_eq("mid_rst_cmt_size", bus.cmt_size, 0);
    step();
    reset = 1'b1;
    bus.wb_ready = 1'b1;
    step();
    check_eq("post_rst_no_stale", bus.wb_valid, 0);
    check_eq("post_rst_cmt", bus.cmt_valid, 0);

    // Ten single 4-thread store commits
    drive(2, 1'b0, 4'hF, 0);
    repeat (10) step();
    idle();
`ifdef VX_COMMIT_PERF_EN
    exp_instrs  = 10;
    exp_threads = 40;
`else
    exp_instrs  = 0;
    exp_threads = 0;
`endif
    check_eq("perf_instrs", bus.perf_instrs, exp_instrs);
    check_eq("perf_threads", bus.perf_threads, exp_threads);

    // Pointer back at 0: ch3 beats ch6
    drive(3, 1'b1, 4'hF, 5);
    drive(6, 1'b1, 4'hF, 5);
    #1;
    check_eq("ptr_rst_ready3", bus.ch_ready[3], 1);
    check_eq("ptr_rst_ready6", bus.ch_ready[6], 0);
    step();
    check_eq("ptr_rst_wb_rd", bus.wb_rd, 13);
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
